// File: rtl/gyn_thread_sched.sv
// gyn_thread_sched: fine-grained round-robin thread scheduler.
// Picks one ready thread per cycle and drives the one-hot read enable of that
// thread's register file. The issued thread ID travels down a writeback-delay
// pipe so that the writeback write enable reaches the owning register file.
// start/halt sequencing lets in-flight issues drain before returning to idle.
module gyn_thread_sched #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2,
    parameter int WB_DELAY    = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   stall,
    input  logic [NUM_THREADS-1:0] thread_ready,
    input  logic                   wb_wena,
    input  logic [3:0]             wb_waddr,
    output logic                   issue_valid,
    output logic [TID_W-1:0]       issue_tid,
    output logic [NUM_THREADS-1:0] rf_read_en,
    output logic                   wb_valid,
    output logic [TID_W-1:0]       wb_tid,
    output logic [NUM_THREADS-1:0] rf_wena,
    output logic                   wb_addr_err,
    output logic                   busy,
    output logic                   drained
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             drained_reg, drained_next;
    logic             issue_valid_reg, issue_valid_next;
    logic [TID_W-1:0] issue_tid_reg, issue_tid_next;
    logic [TID_W-1:0] last_tid_reg, last_tid_next;

    // Writeback-delay pipe, flattened views of the per-stage registers
    logic [WB_DELAY-1:0] pipe_valid_vec;
    logic [TID_W-1:0]    pipe_tid_vec [WB_DELAY];
    logic                pipe_empty;

    // Round-robin search results
    logic             pick_found;
    logic [TID_W-1:0] pick_tid;
    logic [TID_W-1:0] rr_cand;
    int               rr_idx;

    // Writeback routing
    logic wr_req;
    logic wr_ok;

    // Low address bits are decoded inside the register file itself
    logic waddr_unused;
    assign waddr_unused = ^wb_waddr[2:0];

    // Nothing issued and nothing left travelling toward writeback
    assign pipe_empty = ~issue_valid_reg & ~(|pipe_valid_vec);

    // Round-robin search starting just after the last issued thread, wrapping
    // around so the last issued thread itself is tried last
    always_comb begin
        pick_found = 1'b0;
        pick_tid   = last_tid_reg;
        rr_idx     = 0;
        rr_cand    = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            rr_idx  = (int'(last_tid_reg) + i) % NUM_THREADS;
            rr_cand = TID_W'(rr_idx);
            if (!pick_found && thread_ready[rr_cand]) begin
                pick_found = 1'b1;
                pick_tid   = rr_cand;
            end
        end
    end

    // FSM next state; drained flags the single DRAIN->IDLE transition
    always_comb begin
        state_next   = state_reg;
        drained_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next   = ST_IDLE;
                    drained_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Issue selection: a stall freezes issue state, only RUN may issue
    always_comb begin
        issue_valid_next = issue_valid_reg;
        issue_tid_next   = issue_tid_reg;
        last_tid_next    = last_tid_reg;
        if (!stall) begin
            if (state_reg == ST_RUN && pick_found) begin
                issue_valid_next = 1'b1;
                issue_tid_next   = pick_tid;
                last_tid_next    = pick_tid;
            end else begin
                issue_valid_next = 1'b0;
            end
        end
    end

    // State, issue and drained registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            drained_reg     <= 1'b0;
            issue_valid_reg <= 1'b0;
            issue_tid_reg   <= '0;
            last_tid_reg    <= TID_W'(NUM_THREADS - 1);
        end else begin
            state_reg       <= state_next;
            drained_reg     <= drained_next;
            issue_valid_reg <= issue_valid_next;
            issue_tid_reg   <= issue_tid_next;
            last_tid_reg    <= last_tid_next;
        end
    end

    genvar gi;

    // One pipe stage per writeback-delay cycle; stage 0 is fed by the issue regs
    generate
        for (gi = 0; gi < WB_DELAY; gi++) begin : g_pipe
            logic             valid_reg;
            logic [TID_W-1:0] tid_reg;
            logic             valid_in;
            logic [TID_W-1:0] tid_in;

            if (gi == 0) begin : g_head
                assign valid_in = issue_valid_reg;
                assign tid_in   = issue_tid_reg;
            end else begin : g_tail
                assign valid_in = pipe_valid_vec[gi-1];
                assign tid_in   = pipe_tid_vec[gi-1];
            end

            // Advance this stage whenever the pipeline is not frozen
            always_ff @(posedge CLK) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    tid_reg   <= '0;
                end else if (!stall) begin
                    valid_reg <= valid_in;
                    tid_reg   <= tid_in;
                end
            end

            assign pipe_valid_vec[gi] = valid_reg;
            assign pipe_tid_vec[gi]   = tid_reg;
        end
    endgenerate

    // A write only counts once per pipe advance, so stalls gate it off
    assign wr_req      = wb_wena & wb_valid & ~stall;
    assign wr_ok       = wr_req & ~wb_waddr[3];
    assign wb_addr_err = wr_req & wb_waddr[3];

    // One-hot read/write enables decoded per register file
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_rf_en
            assign rf_read_en[gi] = issue_valid_reg & (issue_tid_reg == TID_W'(gi));
            assign rf_wena[gi]    = wr_ok & (wb_tid == TID_W'(gi));
        end
    endgenerate

    assign issue_valid = issue_valid_reg;
    assign issue_tid   = issue_tid_reg;
    assign wb_valid    = pipe_valid_vec[WB_DELAY-1];
    assign wb_tid      = pipe_tid_vec[WB_DELAY-1];
    assign busy        = (state_reg != ST_IDLE);
    assign drained     = drained_reg;

endmodule

// File: tb/tb_gyn_thread_sched.sv
// Testbench for gyn_thread_sched: a behavioural model predicts each cycle's
// issue, and predicted issues are queued as a scoreboard that is popped when
// they arrive at the writeback stage.
module tb_gyn_thread_sched;

    localparam int NT = 4;
    localparam int TW = 2;
    localparam int WD = 4;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          stall = 1'b0;
    logic [NT-1:0] thread_ready = '0;
    logic          wb_wena = 1'b0;
    logic [3:0]    wb_waddr = '0;

    logic          issue_valid;
    logic [TW-1:0] issue_tid;
    logic [NT-1:0] rf_read_en;
    logic          wb_valid;
    logic [TW-1:0] wb_tid;
    logic [NT-1:0] rf_wena;
    logic          wb_addr_err;
    logic          busy;
    logic          drained;

    always #5 CLK = ~CLK;

    gyn_thread_sched #(
        .NUM_THREADS(NT),
        .TID_W(TW),
        .WB_DELAY(WD)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .halt(halt),
        .stall(stall),
        .thread_ready(thread_ready),
        .wb_wena(wb_wena),
        .wb_waddr(wb_waddr),
        .issue_valid(issue_valid),
        .issue_tid(issue_tid),
        .rf_read_en(rf_read_en),
        .wb_valid(wb_valid),
        .wb_tid(wb_tid),
        .rf_wena(rf_wena),
        .wb_addr_err(wb_addr_err),
        .busy(busy),
        .drained(drained)
    );

    typedef struct packed {
        logic          v;
        logic [TW-1:0] t;
    } slot_t;

    // Scoreboard: predicted issues in flight, front entry is the writeback stage
    slot_t pq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drained_cnt = 0;

    // Model state (0 idle, 1 run, 2 drain)
    int            m_state;
    logic          m_iv;
    logic [TW-1:0] m_tid;
    logic [TW-1:0] m_last;
    logic          m_drained;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Rotate the ready mask so the search start lands at bit 0, take lowest set bit
    function automatic void rr_pick(input logic [TW-1:0] last, input logic [NT-1:0] rdy,
                                    output logic found, output logic [TW-1:0] tid);
        logic [2*NT-1:0] rot;
        int base;
        base  = int'(last) + 1;
        rot   = {rdy, rdy} >> base;
        found = 1'b0;
        tid   = last;
        for (int j = NT - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                tid   = TW'((base + j) % NT);
            end
        end
    endfunction

    task automatic model_reset();
        slot_t z;
        z = '0;
        m_state   = 0;
        m_iv      = 1'b0;
        m_tid     = '0;
        m_last    = TW'(NT - 1);
        m_drained = 1'b0;
        pq.delete();
        for (int k = 0; k < WD; k++) pq.push_back(z);
    endtask

    // Check this cycle's outputs against the model, then advance one clock
    task automatic step();
        slot_t         wbs;
        slot_t         ns;
        slot_t         gone;
        logic [NT-1:0] exp_rd;
        logic [NT-1:0] exp_wena;
        logic          exp_err;
        logic          any_v;
        logic          f;
        logic [TW-1:0] t;
        int            n_state;
        logic          n_drained;

        #1;
        wbs      = pq[0];
        exp_rd   = '0;
        exp_wena = '0;
        exp_err  = 1'b0;
        if (m_iv) exp_rd[m_tid] = 1'b1;
        if (wb_wena && wbs.v && !stall) begin
            if (wb_waddr >= 4'd8) exp_err = 1'b1;
            else                  exp_wena[wbs.t] = 1'b1;
        end

        check("issue_valid", issue_valid, m_iv);
        if (m_iv) check("issue_tid", issue_tid, m_tid);
        check("rf_read_en", rf_read_en, exp_rd);
        check("wb_valid", wb_valid, wbs.v);
        if (wbs.v) check("wb_tid", wb_tid, wbs.t);
        check("rf_wena", rf_wena, exp_wena);
        check("wb_addr_err", wb_addr_err, exp_err);
        check("busy", busy, (m_state != 0));
        check("drained", drained, m_drained);
        if (drained === 1'b1) drained_cnt++;

        $display("cyc=%0d rst=%0b st=%0b hl=%0b stl=%0b rdy=%b | iv=%0b tid=%0d rd=%b wbv=%0b wbt=%0d wena=%b err=%0b busy=%0b drn=%0b",
                 cyc, reset, start, halt, stall, thread_ready, issue_valid, issue_tid,
                 rf_read_en, wb_valid, wb_tid, rf_wena, wb_addr_err, busy, drained);

        // Model the coming clock edge
        if (reset) begin
            model_reset();
        end else begin
            any_v = m_iv;
            foreach (pq[k]) any_v = any_v | pq[k].v;
            n_state   = m_state;
            n_drained = 1'b0;
            if (m_state == 0 && start)      n_state = 1;
            else if (m_state == 1 && halt)  n_state = 2;
            else if (m_state == 2 && !any_v) begin
                n_state   = 0;
                n_drained = 1'b1;
            end
            if (!stall) begin
                ns.v = m_iv;
                ns.t = m_tid;
                pq.push_back(ns);
                gone = pq.pop_front();
                if (m_state == 1) begin
                    rr_pick(m_last, thread_ready, f, t);
                    m_iv = f;
                    if (f) begin
                        m_tid  = t;
                        m_last = t;
                    end
                end else begin
                    m_iv = 1'b0;
                end
            end
            m_state   = n_state;
            m_drained = n_drained;
        end

        @(posedge CLK);
        #1;
        cyc++;
        start = 1'b0;
        halt  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int base_cnt;

        // Bring registers to a known state before the model starts tracking
        reset = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset state, then full round robin over all four threads
        step();
        reset = 1'b0;
        step();
        thread_ready = 4'b1111;
        start = 1'b1;
        step();
        repeat (12) step();

        // Sparse ready mask, empty mask, single ready thread
        do_reset();
        thread_ready = 4'b1010;
        start = 1'b1;
        step();
        repeat (6) step();
        thread_ready = 4'b0000;
        repeat (2) step();
        thread_ready = 4'b0001;
        repeat (3) step();

        // Writeback routing to thread 2, then an out-of-range address, then R0
        do_reset();
        thread_ready = 4'b0100;
        wb_wena  = 1'b1;
        wb_waddr = 4'd5;
        start = 1'b1;
        step();
        repeat (7) step();
        wb_waddr = 4'd9;
        repeat (3) step();
        wb_waddr = 4'd0;
        repeat (2) step();
        wb_wena = 1'b0;

        // Stall held three cycles mid-stream with write requests pending
        do_reset();
        thread_ready = 4'b1111;
        start = 1'b1;
        step();
        repeat (6) step();
        stall    = 1'b1;
        wb_wena  = 1'b1;
        wb_waddr = 4'd3;
        repeat (3) step();
        stall = 1'b0;
        repeat (6) step();
        wb_wena = 1'b0;

        // Halt with the pipe full; start during drain must be ignored
        base_cnt = drained_cnt;
        halt = 1'b1;
        step();
        start = 1'b1;
        step();
        repeat (9) step();
        check("drained_pulses", drained_cnt - base_cnt, 1);

        // Reset with the pipe full discards everything in flight
        do_reset();
        thread_ready = 4'b1111;
        start = 1'b1;
        step();
        repeat (6) step();
        wb_wena  = 1'b1;
        wb_waddr = 4'd2;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
        start = 1'b1;
        step();
        repeat (6) step();
        wb_wena = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
